freq_meter_mc: RTL and testbench
================================

FREQ_METER_MC -- requirements
Module: freq_meter_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of measured input channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of per-channel edge counter and result.
REQ-003 Parameter GATE_CYCLES, default 50000000: gate window length in clk cycles, at least 2.
REQ-004 clk  input  1  reference clock; all logic in this domain.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 sig_in  input  NUM_CH  measured signals, asynchronous to clk, frequency below clk/2.
REQ-007 start  input  1  single-cycle request to begin one measurement.
REQ-008 cont_en  input  1  continuous mode; windows repeat back-to-back while high.
REQ-009 abort  input  1  cancel the window in progress.
REQ-010 ch_sel  input  max(1,$clog2(NUM_CH))  channel selected for readout.
REQ-011 result  output  CNT_W  latched edge count of channel ch_sel.
REQ-012 ovf  output  1  overflow flag of channel ch_sel; present only with FMC_SAT_EN.
REQ-013 busy  output  1  high while in GATE or DONE.
REQ-014 done  output  1  one-cycle pulse when results are updated.
REQ-015 valid  output  1  high once at least one window has completed since reset.

Function
REQ-016 Each sig_in bit SHALL pass a 2-flop synchronizer and then a rising-edge detector; one detected edge adds 1 to that channel's counter.
REQ-017 FSM states: IDLE, GATE, DONE.
- IDLE to GATE on start=1 or cont_en=1.
- GATE to DONE after exactly GATE_CYCLES cycles in GATE.
- DONE to GATE if cont_en=1, otherwise DONE to IDLE.
REQ-018 Entering GATE SHALL clear all counters and the gate timer; edges are counted only during GATE cycles.
REQ-019 An edge detected in the last GATE cycle SHALL be included in the result; edges detected in IDLE or DONE are discarded.
REQ-020 On the GATE-to-DONE transition, all NUM_CH counters SHALL be copied to the result registers in the same clock edge.
REQ-021 done SHALL be high during the single DONE cycle, and valid SHALL be set in that same cycle.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 abort in GATE SHALL force IDLE on the next edge; result registers, valid and done are unchanged.
REQ-024 abort outranks start and cont_en in the same cycle.
REQ-025 result SHALL be a registered-free mux of the result registers indexed by ch_sel; ch_sel >= NUM_CH gives result=0 and ovf=0.
REQ-026 Without FMC_SAT_EN, counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-027 reset_n low SHALL immediately clear the following: FSM to IDLE, counters, gate timer, synchronizer and edge flops, result registers, overflow flags, done, valid, busy.
REQ-028 Reset asserted mid-window SHALL discard the window, with no done pulse.
REQ-029 Deassertion SHALL be synchronised externally; the first start is accepted no earlier than the first clk edge after release.

Configuration
REQ-030 Macro FMC_SAT_EN defined: each counter saturates at 2^CNT_W-1 and sets its channel overflow flag.
- Overflow flags are cleared when GATE is entered and latched at DONE with the results.
- The ovf port exists.
REQ-031 Macro FMC_SAT_EN undefined: no ovf port, no flags, and counters wrap as in REQ-026.

Verification
REQ-032 NUM_CH=2, GATE_CYCLES=100, sig_in[0]=clk/4 square wave, sig_in[1]=0, single start -> done pulse 101 cycles after start is sampled; result ch0 = 25 ±1, ch1 = 0; valid=1.
REQ-033 cont_en=1 for 3 windows, sig_in[0]=clk/10 -> three done pulses spaced GATE_CYCLES+1 cycles apart; each result 10 ±1; busy stays high throughout.
REQ-034 abort at cycle 50 of the second window -> IDLE next cycle; no done pulse; result still holds the first-window value.
REQ-035 FMC_SAT_EN, CNT_W=4, 20 edges in a window -> result=15, ovf=1. Without the macro, the same stimulus gives result=4 and no ovf port.
REQ-036 reset_n pulsed low mid-GATE -> all outputs 0 within the reset pulse, no done pulse; start pulsed while busy -> ignored, window length unchanged.

Source files
------------

// File: rtl/freq_meter_mc_if.sv
// freq_meter_mc_if: control/readout bundle for the multi-channel frequency meter.
// The ovf signal exists only when FMC_SAT_EN is defined.
interface freq_meter_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [NUM_CH-1:0] sig_in;
    logic              start;
    logic              cont_en;
    logic              abort;
    logic [SEL_W-1:0]  ch_sel;
    logic [CNT_W-1:0]  result;
`ifdef FMC_SAT_EN
    logic              ovf;
`endif
    logic              busy;
    logic              done;
    logic              valid;
    modport master (
`ifdef FMC_SAT_EN
        input  ovf,
`endif
        input  result, busy, done, valid,
        output sig_in, start, cont_en, abort, ch_sel
    );
    modport slave (
`ifdef FMC_SAT_EN
        output ovf,
`endif
        output result, busy, done, valid,
        input  sig_in, start, cont_en, abort, ch_sel
    );
endinterface

// File: rtl/freq_meter_mc.sv
// freq_meter_mc: gated edge counter per channel with single/continuous windows.
// Define FMC_SAT_EN for saturating counters with per-channel overflow flags.
module freq_meter_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset_n,
    freq_meter_mc_if.slave  bus
);
    localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int NSEL  = 2 ** SEL_W;
    localparam int TW    = $clog2(GATE_CYCLES);
    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
    state_t            state;
    logic [NUM_CH-1:0] s1, s2, s3, edge_d;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    // Padded to the full ch_sel range; unused entries stay zero for readout.
    logic [CNT_W-1:0]  res [NSEL];
    logic              busy, done, valid, go, last;
`ifdef FMC_SAT_EN
    logic [NUM_CH-1:0] sat, sat_nxt;
    logic [NSEL-1:0]   ovf_r;
`endif
    assign edge_d = s2 & ~s3;
    assign last   = timer == TW'(GATE_CYCLES - 1);
    // abort outranks any request to (re)enter GATE
    assign go     = !bus.abort && (state == IDLE ? (bus.start || bus.cont_en) :
                                   state == DONE ? bus.cont_en : 1'b0);
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef FMC_SAT_EN
            cnt_nxt[i] = (edge_d[i] && cnt[i] != '1) ? cnt[i] + CNT_W'(1) : cnt[i];
            sat_nxt[i] = sat[i] | (edge_d[i] && cnt[i] == '1);
`else
            cnt_nxt[i] = cnt[i] + CNT_W'(edge_d[i]);
`endif
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            timer <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            for (int i = 0; i < NSEL; i++) res[i] <= '0;
`ifdef FMC_SAT_EN
            sat   <= '0;
            ovf_r <= '0;
`endif
        end else begin
            s1   <= bus.sig_in;
            s2   <= s1;
            s3   <= s2;
            done <= 1'b0;
            if (go) begin
                state <= GATE;
                busy  <= 1'b1;
                timer <= '0;
                for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
`ifdef FMC_SAT_EN
                sat <= '0;
`endif
            end else begin
                case (state)
                    GATE: begin
                        if (bus.abort) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                            for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
`ifdef FMC_SAT_EN
                            sat <= sat_nxt;
`endif
                            if (last) begin
                                state <= DONE;
                                done  <= 1'b1;
                                valid <= 1'b1;
                                for (int i = 0; i < NUM_CH; i++) res[i] <= cnt_nxt[i];
`ifdef FMC_SAT_EN
                                ovf_r[NUM_CH-1:0] <= sat_nxt;
`endif
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.result = res[bus.ch_sel];
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.valid  = valid;
`ifdef FMC_SAT_EN
    assign bus.ovf    = ovf_r[bus.ch_sel];
`endif
endmodule

// File: tb/tb_freq_meter_mc.sv
// tb_freq_meter_mc: directed checks of freq_meter_mc; two instances (8-bit and 4-bit counters)
// share stimulus. FMC_SAT_EN selects the saturating expectations.
module tb_freq_meter_mc;
    localparam int GC = 100;
`ifdef FMC_SAT_EN
    localparam int B_EXP = 15;
`else
    localparam int B_EXP = 4;
`endif
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sig0 = 1'b0;
    logic       start = 1'b0, cont_en = 1'b0, abort = 1'b0;
    logic       sel_a = 1'b0;
    logic [1:0] sel_b = 2'd0;
    int         per = 0, ph = 0;
    int         n_chk = 0, n_fail = 0;
    int         lat, last, ndone, busy_bad;

    freq_meter_mc_if #(.NUM_CH(2), .CNT_W(8)) ifa ();
    freq_meter_mc_if #(.NUM_CH(3), .CNT_W(4)) ifb ();

    assign ifa.sig_in  = {1'b0, sig0};
    assign ifa.start   = start;
    assign ifa.cont_en = cont_en;
    assign ifa.abort   = abort;
    assign ifa.ch_sel  = sel_a;
    assign ifb.sig_in  = {sig0, 1'b0, sig0};
    assign ifb.start   = start;
    assign ifb.cont_en = cont_en;
    assign ifb.abort   = abort;
    assign ifb.ch_sel  = sel_b;

    freq_meter_mc #(.NUM_CH(2), .CNT_W(8), .GATE_CYCLES(GC)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    freq_meter_mc #(.NUM_CH(3), .CNT_W(4), .GATE_CYCLES(GC)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    always #5 clk = ~clk;

    // square wave of period per clk cycles, high for per/2 cycles
    always begin
        @(posedge clk);
        #3;
        if (per == 0) begin
            sig0 = 1'b0;
            ph   = 0;
        end else begin
            ph   = (ph + 1) % per;
            sig0 = ph < per / 2;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (ifa.done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset busy", ifa.busy, 0);
        check("reset done", ifa.done, 0);
        check("reset valid", ifa.valid, 0);
        check("reset result", ifa.result, 0);
        reset_n = 1'b1;
        tick();

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("abort beats start", ifa.busy, 0);

        // single window, clk/4 on ch0, with an ignored start mid-window
        per = 4;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (ifa.done !== 1'b1 && lat < 300) begin
            start = (lat == 40);
            if (lat == 40) check("busy in gate", ifa.busy, 1);
            tick();
            lat++;
        end
        start = 1'b0;
        check("single latency", lat, GC + 1);
        check("single valid", ifa.valid, 1);
        check("single busy in done", ifa.busy, 1);
        check("single ch0", ifa.result, 25);
        sel_a = 1'b1;
        #1;
        check("single ch1", ifa.result, 0);
        sel_a = 1'b0;
        tick();
        check("single done drop", ifa.done, 0);
        check("single idle", ifa.busy, 0);
        check("single hold", ifa.result, 25);

        // continuous, three windows at clk/10
        per = 10;
        repeat (10) tick();
        cont_en = 1'b1;
        tick();
        busy_bad = 0; ndone = 0; lat = 0; last = 0;
        while (ndone < 3 && lat < 400) begin
            tick();
            lat++;
            if (ifa.busy !== 1'b1) busy_bad++;
            if (ifa.done === 1'b1) begin
                ndone++;
                check("cont result", ifa.result, 10);
                if (ndone > 1) check("cont spacing", lat - last, GC + 1);
                last = lat;
                if (ndone == 3) cont_en = 1'b0;
            end
        end
        check("cont done count", ndone, 3);
        check("cont busy gaps", busy_bad, 0);
        tick();
        check("cont stop", ifa.busy, 0);

        // abort at cycle 50 of the second continuous window
        per = 4;
        repeat (10) tick();
        cont_en = 1'b1;
        tick();
        wait_done(300, lat);
        check("abort first done", ifa.done, 1);
        check("abort first result", ifa.result, 25);
        repeat (50) tick();
        abort = 1'b1; cont_en = 1'b0;
        tick();
        abort = 1'b0;
        check("abort idle", ifa.busy, 0);
        check("abort no done", ifa.done, 0);
        ndone = 0;
        repeat (150) begin
            tick();
            if (ifa.done === 1'b1) ndone++;
        end
        check("abort no later done", ndone, 0);
        check("abort result kept", ifa.result, 25);
        check("abort valid kept", ifa.valid, 1);

        // 20 edges into 4-bit counters
        per = 5;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, lat);
        check("sat done a", ifa.done, 1);
        check("sat done b", ifb.done, 1);
        check("sat a ch0", ifa.result, 20);
        check("sat b ch0", ifb.result, B_EXP);
`ifdef FMC_SAT_EN
        check("sat b ovf0", ifb.ovf, 1);
`endif
        sel_b = 2'd1;
        #1;
        check("sat b ch1", ifb.result, 0);
`ifdef FMC_SAT_EN
        check("sat b ovf1", ifb.ovf, 0);
`endif
        sel_b = 2'd2;
        #1;
        check("sat b ch2", ifb.result, B_EXP);
        sel_b = 2'd3;
        #1;
        check("sel out of range", ifb.result, 0);
`ifdef FMC_SAT_EN
        check("sel out of range ovf", ifb.ovf, 0);
`endif
        sel_b = 2'd0;
        repeat (3) tick();

        // reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("pre-reset busy", ifa.busy, 1);
        reset_n = 1'b0;
        #2;
        check("mid reset busy", ifa.busy, 0);
        check("mid reset done", ifa.done, 0);
        check("mid reset valid", ifa.valid, 0);
        check("mid reset result", ifa.result, 0);
        check("mid reset b result", ifb.result, 0);
        tick();
        reset_n = 1'b1;
        ndone = 0;
        repeat (150) begin
            tick();
            if (ifa.done === 1'b1) ndone++;
        end
        check("post reset no done", ndone, 0);
        check("post reset valid", ifa.valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
